// File: rtl/exe_mdu_ctrl_pkg.sv
// exe_mdu_ctrl_pkg
//   Shared types for the execute-stage multi-cycle unit sequencer.
//   mul_op_t    : which half / signedness of the 64b product is wanted
//   mul_op_t    : LO = MUL.W, HI = MULH.W, HIU = MULH.WU
//   div_op_t    : Q = DIV.W, QU = DIV.WU, R = MOD.W, RU = MOD.WU
//   mdu_state_t : sequencer FSM states
package exe_mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'd0,
        MUL_HI  = 2'd1,
        MUL_HIU = 2'd2
    } mul_op_t;

    typedef enum logic [1:0] {
        DIV_Q  = 2'd0,
        DIV_QU = 2'd1,
        DIV_R  = 2'd2,
        DIV_RU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_DIV_BUSY = 2'd2,
        S_HOLD     = 2'd3
    } mdu_state_t;

    // Signed variants: LO/HI multiply and Q/R divide.
    function automatic logic mul_is_signed(input mul_op_t op);
        return op != MUL_HIU;
    endfunction

    function automatic logic div_is_signed(input div_op_t op);
        return (op == DIV_Q) || (op == DIV_R);
    endfunction

    function automatic logic div_wants_rem(input div_op_t op);
        return (op == DIV_R) || (op == DIV_RU);
    endfunction

endpackage

// File: rtl/exe_mdu_ctrl_if.sv
// exe_mdu_ctrl_if
//   Bundles everything between the sequencer and its neighbours:
//   - request/pipeline side : req_*, stall_i, flush_i in; eu_stall, res_* , lat_err out
//   - multiplier side       : mul_start/mul_signed/mul_abort out; mul_done/mul_out in
//   - divider side          : div_start/div_signed/div_abort out; div_done/div_q/div_r in
//   modport master : the sequencer itself
//   modport slave  : the environment (execute register, ctrl, and the two units)
interface exe_mdu_ctrl_if
    import exe_mdu_ctrl_pkg::*;
#(
    parameter int DW = 32
) ();

    logic          req_valid;
    logic          req_is_mul;
    logic          req_is_div;
    mul_op_t       req_mul_op;
    div_op_t       req_div_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          stall_i;
    logic          flush_i;
    logic          eu_stall;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          lat_err;

    logic            mul_start;
    logic            mul_signed;
    logic            mul_abort;
    logic            mul_done;
    logic [2*DW-1:0] mul_out;

    logic          div_start;
    logic          div_signed;
    logic          div_abort;
    logic          div_done;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_r;

    modport master (
        input  req_valid, req_is_mul, req_is_div, req_mul_op, req_div_op,
               req_a, req_b, stall_i, flush_i,
               mul_done, mul_out, div_done, div_q, div_r,
        output eu_stall, res_valid, res_data, lat_err,
               mul_start, mul_signed, mul_abort,
               div_start, div_signed, div_abort
    );

    modport slave (
        output req_valid, req_is_mul, req_is_div, req_mul_op, req_div_op,
               req_a, req_b, stall_i, flush_i,
               mul_done, mul_out, div_done, div_q, div_r,
        input  eu_stall, res_valid, res_data, lat_err,
               mul_start, mul_signed, mul_abort,
               div_start, div_signed, div_abort
    );

endinterface

// File: rtl/exe_mdu_ctrl.sv
// exe_mdu_ctrl
//   Sequences one MUL/DIV instruction from the execute register through the
//   iterative multiplier or divider: start pulse, wait for done, latch the
//   selected 32b result, hold it (res_valid) until the pipeline advances.
//   A watchdog flags units that take longer than MAX_LAT cycles (sticky lat_err).
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - exe_mdu_ctrl_if.master (request/pipeline, multiplier, divider)
//   Parameters:
//     DW        - operand/result width
//     MAX_LAT   - watchdog limit in cycles counted from the start cycle
//     DIV0_FAST - divide by zero resolves locally in one cycle (q=0, r=dividend)
module exe_mdu_ctrl
    import exe_mdu_ctrl_pkg::*;
#(
    parameter int DW        = 32,
    parameter int MAX_LAT   = 40,
    parameter bit DIV0_FAST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    exe_mdu_ctrl_if.master bus
);

    localparam int            CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LAT);

    mdu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mul_op_t       mul_op_q, mul_op_d;
    div_op_t       div_op_q, div_op_d;
    logic          sgn_q, sgn_d;
    logic [DW-1:0] res_q, res_d;
    logic          lat_err_q, lat_err_d;

    logic mdu_req;
    logic div0;
    logic busy_done;
    logic mul_start;
    logic div_start;
    logic mul_abort;
    logic div_abort;
    logic wd_hit;

    assign mdu_req = bus.req_valid & (bus.req_is_mul | bus.req_is_div);
    assign div0    = DIV0_FAST && (bus.req_b == '0);

    // Only the unit we are waiting on may complete the instruction.
    assign busy_done = ((state_q == S_MUL_BUSY) & bus.mul_done) |
                       ((state_q == S_DIV_BUSY) & bus.div_done);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_op_d  = mul_op_q;
        div_op_d  = div_op_q;
        sgn_d     = sgn_q;
        res_d     = res_q;
        lat_err_d = lat_err_q;
        mul_start = 1'b0;
        div_start = 1'b0;
        mul_abort = 1'b0;
        div_abort = 1'b0;
        wd_hit    = 1'b0;

        if (bus.flush_i) begin
            // Flush wins over issue, completion and hold alike.
            state_d   = S_IDLE;
            cnt_d     = '0;
            res_d     = '0;
            mul_abort = (state_q == S_MUL_BUSY);
            div_abort = (state_q == S_DIV_BUSY);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mdu_req) begin
                        cnt_d = '0;
                        // A malformed request flagged as both goes to the multiplier.
                        if (bus.req_is_mul) begin
                            mul_start = 1'b1;
                            mul_op_d  = bus.req_mul_op;
                            sgn_d     = mul_is_signed(bus.req_mul_op);
                            state_d   = S_MUL_BUSY;
                        end else begin
                            div_op_d = bus.req_div_op;
                            sgn_d    = div_is_signed(bus.req_div_op);
                            if (div0) begin
                                res_d   = div_wants_rem(bus.req_div_op) ? bus.req_a : '0;
                                state_d = S_HOLD;
                            end else begin
                                div_start = 1'b1;
                                state_d   = S_DIV_BUSY;
                            end
                        end
                    end
                end
                S_MUL_BUSY, S_DIV_BUSY: begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                    if (busy_done) begin
                        if (state_q == S_MUL_BUSY)
                            res_d = (mul_op_q == MUL_LO) ? bus.mul_out[DW-1:0]
                                                         : bus.mul_out[2*DW-1:DW];
                        else
                            res_d = div_wants_rem(div_op_q) ? bus.div_r : bus.div_q;
                        state_d = S_HOLD;
                    end else if (cnt_d == CNT_MAX) begin
                        // cnt_d equals the number of cycles since the start pulse,
                        // so the flag shows in the cycle the limit is reached.
                        wd_hit    = 1'b1;
                        lat_err_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!bus.stall_i) begin
                        state_d = S_IDLE;
                        res_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mul_op_q  <= MUL_LO;
            div_op_q  <= DIV_Q;
            sgn_q     <= 1'b0;
            res_q     <= '0;
            lat_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mul_op_q  <= mul_op_d;
            div_op_q  <= div_op_d;
            sgn_q     <= sgn_d;
            res_q     <= res_d;
            lat_err_q <= lat_err_d;
        end
    end

    // Units share rst, so nothing is pulsed at them while it is asserted.
    assign bus.mul_start  = mul_start & ~rst;
    assign bus.div_start  = div_start & ~rst;
    assign bus.mul_abort  = mul_abort & ~rst;
    assign bus.div_abort  = div_abort & ~rst;
    assign bus.mul_signed = ~rst & (mul_start ? mul_is_signed(bus.req_mul_op)
                                              : (state_q == S_MUL_BUSY) & sgn_q);
    assign bus.div_signed = ~rst & (div_start ? div_is_signed(bus.req_div_op)
                                              : (state_q == S_DIV_BUSY) & sgn_q);

    assign bus.res_valid = (state_q == S_HOLD);
    assign bus.res_data  = res_q;
    assign bus.eu_stall  = mdu_req & ~bus.res_valid & ~rst;
    assign bus.lat_err   = lat_err_q | (wd_hit & ~rst);

endmodule

// File: tb/tb_exe_mdu_ctrl.sv
module tb_exe_mdu_ctrl;
    import exe_mdu_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   mul_starts;
    int   div_starts;

    exe_mdu_ctrl_if #(.DW(32)) bus ();

    exe_mdu_ctrl #(.DW(32), .MAX_LAT(8), .DIV0_FAST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mul_start) mul_starts <= mul_starts + 1;
        if (bus.div_start) div_starts <= div_starts + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_is_mul = 1'b0;
        bus.req_is_div = 1'b0;
        bus.req_mul_op = MUL_LO;
        bus.req_div_op = DIV_Q;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.stall_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.mul_done   = 1'b0;
        bus.mul_out    = '0;
        bus.div_done   = 1'b0;
        bus.div_q      = '0;
        bus.div_r      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if ({bus.res_valid, bus.eu_stall, bus.lat_err, bus.mul_start, bus.div_start,
             bus.mul_abort, bus.div_abort, bus.mul_signed, bus.div_signed} !== 9'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {bus.res_valid, bus.eu_stall, bus.lat_err, bus.mul_start, bus.div_start,
                      bus.mul_abort, bus.div_abort, bus.mul_signed, bus.div_signed});
        end
        tests++;
        if (bus.res_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got %h want 00000000", bus.res_data);
        end
    endtask

    // Bench plays the multiplier: done pulse 'lat' cycles after the start cycle.
    task automatic test_mul(input string name, input mul_op_t op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] prod,
                            input logic [31:0] exp, input logic exp_sgn, input int lat);
        bus.req_valid  = 1'b1;
        bus.req_is_mul = 1'b1;
        bus.req_mul_op = op;
        bus.req_a      = a;
        bus.req_b      = b;
        #1;
        tests++;
        if (bus.mul_start !== 1'b1 || bus.mul_signed !== exp_sgn || bus.eu_stall !== 1'b1 ||
            bus.div_start !== 1'b0) begin
            fails++;
            $display("FAIL %s_issue: start=%b signed=%b stall=%b dstart=%b want 1 %b 1 0",
                     name, bus.mul_start, bus.mul_signed, bus.eu_stall, bus.div_start, exp_sgn);
        end
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c == lat) begin
                bus.mul_done = 1'b1;
                bus.mul_out  = prod;
            end
            #1;
            tests++;
            if (bus.mul_start !== 1'b0 || bus.eu_stall !== 1'b1 || bus.res_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s_busy%0d: start=%b stall=%b rv=%b want 0 1 0",
                         name, c, bus.mul_start, bus.eu_stall, bus.res_valid);
            end
        end
        tick();
        bus.mul_done = 1'b0;
        bus.mul_out  = '0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.eu_stall !== 1'b0) begin
            fails++;
            $display("FAIL %s_result: rv=%b data=%h stall=%b want 1 %h 0",
                     name, bus.res_valid, bus.res_data, bus.eu_stall, exp);
        end
        tick();
        bus.req_valid  = 1'b0;
        bus.req_is_mul = 1'b0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.mul_start !== 1'b0) begin
            fails++;
            $display("FAIL %s_retire: rv=%b start=%b want 0 0", name, bus.res_valid, bus.mul_start);
        end
    endtask

    task automatic test_div(input string name, input div_op_t op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                            input logic [31:0] exp, input logic exp_sgn, input int lat);
        bus.req_valid  = 1'b1;
        bus.req_is_div = 1'b1;
        bus.req_div_op = op;
        bus.req_a      = a;
        bus.req_b      = b;
        #1;
        tests++;
        if (bus.div_start !== 1'b1 || bus.div_signed !== exp_sgn || bus.eu_stall !== 1'b1 ||
            bus.mul_start !== 1'b0) begin
            fails++;
            $display("FAIL %s_issue: start=%b signed=%b stall=%b mstart=%b want 1 %b 1 0",
                     name, bus.div_start, bus.div_signed, bus.eu_stall, bus.mul_start, exp_sgn);
        end
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c == lat) begin
                bus.div_done = 1'b1;
                bus.div_q    = q;
                bus.div_r    = r;
            end
            #1;
        end
        tick();
        bus.div_done = 1'b0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.eu_stall !== 1'b0) begin
            fails++;
            $display("FAIL %s_result: rv=%b data=%h stall=%b want 1 %h 0",
                     name, bus.res_valid, bus.res_data, bus.eu_stall, exp);
        end
        tick();
        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'b0;
        #1;
    endtask

    task automatic test_div0(input string name, input div_op_t op, input logic [31:0] a,
                             input logic [31:0] exp);
        int base;
        base = div_starts;
        bus.req_valid  = 1'b1;
        bus.req_is_div = 1'b1;
        bus.req_div_op = op;
        bus.req_a      = a;
        bus.req_b      = 32'h0;
        #1;
        tests++;
        if (bus.div_start !== 1'b0 || bus.eu_stall !== 1'b1) begin
            fails++;
            $display("FAIL %s_issue: start=%b stall=%b want 0 1", name, bus.div_start, bus.eu_stall);
        end
        tick();
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.div_start !== 1'b0) begin
            fails++;
            $display("FAIL %s_result: rv=%b data=%h start=%b want 1 %h 0",
                     name, bus.res_valid, bus.res_data, bus.div_start, exp);
        end
        tick();
        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'b0;
        #1;
        tests++;
        if (div_starts - base !== 0 || bus.res_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_nostart: starts=%0d rv=%b want 0 0", name, div_starts - base, bus.res_valid);
        end
    endtask

    task automatic test_flush();
        int base;
        bus.req_valid  = 1'b1;
        bus.req_is_div = 1'b1;
        bus.req_div_op = DIV_Q;
        bus.req_a      = 32'd100;
        bus.req_b      = 32'd7;
        tick();
        tick();
        base           = div_starts;
        bus.flush_i    = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'b0;
        #1;
        tests++;
        if (bus.div_abort !== 1'b1 || bus.mul_abort !== 1'b0) begin
            fails++;
            $display("FAIL flush_abort: div_abort=%b mul_abort=%b want 1 0", bus.div_abort, bus.mul_abort);
        end
        tick();
        bus.flush_i = 1'b0;
        #1;
        tests++;
        if (bus.div_abort !== 1'b0 || bus.res_valid !== 1'b0 || bus.eu_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: abort=%b rv=%b stall=%b want 0 0 0",
                     bus.div_abort, bus.res_valid, bus.eu_stall);
        end
        tick();
        bus.div_done = 1'b1;
        bus.div_q    = 32'd14;
        #1;
        tick();
        bus.div_done = 1'b0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 32'h0 || div_starts != base) begin
            fails++;
            $display("FAIL flush_late_done: rv=%b data=%h restarts=%0d want 0 00000000 0",
                     bus.res_valid, bus.res_data, div_starts - base);
        end
        // Request arriving together with a flush must not start anything.
        bus.req_valid  = 1'b1;
        bus.req_is_mul = 1'b1;
        bus.req_mul_op = MUL_LO;
        bus.flush_i    = 1'b1;
        #1;
        tests++;
        if (bus.mul_start !== 1'b0 || bus.mul_abort !== 1'b0) begin
            fails++;
            $display("FAIL flush_nostart: start=%b abort=%b want 0 0", bus.mul_start, bus.mul_abort);
        end
        tick();
        bus.flush_i    = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_is_mul = 1'b0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.eu_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_nostart_idle: rv=%b stall=%b want 0 0", bus.res_valid, bus.eu_stall);
        end
    endtask

    task automatic test_spurious_done();
        bus.req_valid  = 1'b1;
        bus.req_is_mul = 1'b1;
        bus.req_mul_op = MUL_LO;
        bus.req_a      = 32'd6;
        bus.req_b      = 32'd9;
        tick();
        bus.div_done = 1'b1;
        bus.div_q    = 32'd55;
        bus.div_r    = 32'd55;
        #1;
        tick();
        bus.div_done = 1'b0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.eu_stall !== 1'b1) begin
            fails++;
            $display("FAIL spurious_div_done: rv=%b stall=%b want 0 1", bus.res_valid, bus.eu_stall);
        end
        bus.mul_done = 1'b1;
        bus.mul_out  = 64'h0000_0000_0000_0036;
        tick();
        bus.mul_done = 1'b0;
        bus.mul_out  = '0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h36) begin
            fails++;
            $display("FAIL spurious_then_mul: rv=%b data=%h want 1 00000036", bus.res_valid, bus.res_data);
        end
        tick();
        bus.req_valid  = 1'b0;
        bus.req_is_mul = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        int base;
        base           = mul_starts;
        bus.stall_i    = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_is_mul = 1'b1;
        bus.req_mul_op = MUL_HI;
        bus.req_a      = 32'd5;
        bus.req_b      = 32'd3;
        tick();
        tick();
        bus.mul_done = 1'b1;
        bus.mul_out  = 64'h0000_0007_0000_0001;
        tick();
        bus.mul_done = 1'b0;
        bus.mul_out  = '0;
        #1;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h7 || bus.mul_start !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: rv=%b data=%h start=%b want 1 00000007 0",
                         c, bus.res_valid, bus.res_data, bus.mul_start);
            end
            tick();
        end
        bus.stall_i = 1'b0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b1 || mul_starts - base !== 1) begin
            fails++;
            $display("FAIL stall_release: rv=%b starts=%0d want 1 1", bus.res_valid, mul_starts - base);
        end
        // Next instruction is in the execute register the cycle after release.
        tick();
        bus.req_mul_op = MUL_LO;
        #1;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.mul_start !== 1'b1) begin
            fails++;
            $display("FAIL b2b_issue: rv=%b start=%b want 0 1", bus.res_valid, bus.mul_start);
        end
        tick();
        bus.flush_i    = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_is_mul = 1'b0;
        #1;
        tests++;
        if (bus.mul_abort !== 1'b1 || bus.div_abort !== 1'b0) begin
            fails++;
            $display("FAIL b2b_mul_abort: mul_abort=%b div_abort=%b want 1 0", bus.mul_abort, bus.div_abort);
        end
        tick();
        bus.flush_i = 1'b0;
        #1;
        tests++;
        if (mul_starts - base !== 2 || bus.mul_abort !== 1'b0) begin
            fails++;
            $display("FAIL b2b_starts: starts=%0d abort=%b want 2 0", mul_starts - base, bus.mul_abort);
        end
    endtask

    task automatic test_lat_err();
        bus.req_valid  = 1'b1;
        bus.req_is_mul = 1'b1;
        bus.req_mul_op = MUL_LO;
        bus.req_a      = 32'd1;
        bus.req_b      = 32'd1;
        #1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            tests++;
            if (bus.lat_err !== (c >= 8) || bus.eu_stall !== 1'b1) begin
                fails++;
                $display("FAIL lat_err_c%0d: lat_err=%b stall=%b want %b 1",
                         c, bus.lat_err, bus.eu_stall, c >= 8);
            end
        end
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (bus.mul_abort !== 1'b0) begin
            fails++;
            $display("FAIL lat_rst_abort: abort=%b want 0", bus.mul_abort);
        end
        tick();
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_is_mul = 1'b0;
        #1;
        tests++;
        if (bus.lat_err !== 1'b0 || bus.eu_stall !== 1'b0 || bus.res_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_rst_clear: lat_err=%b stall=%b rv=%b want 0 0 0",
                     bus.lat_err, bus.eu_stall, bus.res_valid);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        mul_starts = 0;
        div_starts = 0;
        rst        = 1'b1;
        idle_inputs();
        test_reset();
        test_mul("mulw", MUL_LO, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 32'hFFFF_FFEB, 1'b1, 3);
        test_mul("mulhwu", MUL_HIU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 32'h0000_0001, 1'b0, 2);
        test_mul("mulhw", MUL_HI, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 2);
        test_div("divw", DIV_Q, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 4);
        test_div("modwu", DIV_RU, 32'd7, 32'd2, 32'd3, 32'd1, 32'd1, 1'b0, 5);
        test_div0("div0_rem", DIV_R, 32'h1234_5678, 32'h1234_5678);
        test_div0("div0_quo", DIV_QU, 32'h1234_5678, 32'h0000_0000);
        test_flush();
        test_spurious_done();
        test_back_to_back();
        test_lat_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
